// File: rtl/remote_comm_nbyte_pkg.sv
// Shared state encoding, default timeout and checksum helper for the remote_comm_nbyte transceiver.
package remote_comm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TX_LOAD = 2'd1,
    TX_WAIT = 2'd2,
    RX_WAIT = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT_CYC = 2_000_000;

  // Returns the byte that brings the 8-bit sum of the low nbytes of data to zero.
  function automatic logic [7:0] chksum8(input logic [63:0] data, input int nbytes);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) sum = sum + data[8*i +: 8];
    end
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/remote_comm_nbyte_uart.sv
// 8N1 UART transceiver with level tx_done/rx_rdy flags; BAUD_DIV clocks per bit.
module uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int BW = ($clog2(BAUD_DIV) > 0) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  logic [8:0]    tx_shft;
  logic [3:0]    tx_bit_cnt;
  logic [BW-1:0] tx_baud;
  logic          tx_busy;

  // Shift register resets to all ones so the line idles high the moment reset hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft    <= '1;
      tx_bit_cnt <= '0;
      tx_baud    <= '0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else if (trmt) begin
      tx_shft    <= {tx_data, 1'b0};
      tx_bit_cnt <= '0;
      tx_baud    <= '0;
      tx_busy    <= 1'b1;
      tx_done    <= 1'b0;
    end else if (tx_busy && tx_baud == BAUD_MAX) begin
      tx_baud    <= '0;
      tx_shft    <= {1'b1, tx_shft[8:1]};
      tx_bit_cnt <= tx_bit_cnt + 4'd1;
      if (tx_bit_cnt == 4'd9) begin
        tx_busy <= 1'b0;
        tx_done <= 1'b1;
      end
    end else if (tx_busy) begin
      tx_baud <= tx_baud + 1'b1;
    end
  end

  assign TX = tx_shft[0];

  logic          rx_ff1, rx_ff2;
  logic [8:0]    rx_shft;
  logic [3:0]    rx_bit_cnt;
  logic [BW-1:0] rx_baud;
  logic          rx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
    end
  end

  // Samples mid-bit; stop-bit sample completes the byte so the line is idle on return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft    <= '0;
      rx_bit_cnt <= '0;
      rx_baud    <= '0;
      rx_busy    <= 1'b0;
      rx_rdy     <= 1'b0;
    end else begin
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_ff2) begin
          rx_busy    <= 1'b1;
          rx_baud    <= BAUD_HALF;
          rx_bit_cnt <= '0;
          rx_rdy     <= 1'b0;
        end
      end else if (rx_baud == BAUD_MAX) begin
        rx_baud <= '0;
        if (rx_bit_cnt == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end else begin
          rx_shft    <= {rx_ff2, rx_shft[8:1]};
          rx_bit_cnt <= rx_bit_cnt + 4'd1;
        end
      end else begin
        rx_baud <= rx_baud + 1'b1;
      end
    end
  end

  assign rx_data = rx_shft[8:1];

endmodule

// File: rtl/remote_comm_nbyte.sv
// Host-side command/response transceiver: sends CMD_BYTES MSB-first, collects RESP_BYTES with timeout.
// Optional checksum byte in both directions when REMOTE_COMM_CHKSUM_EN is defined.
module remote_comm_nbyte
  import remote_comm_pkg::*;
#(
  parameter int  CMD_BYTES   = 2,
  parameter int  RESP_BYTES  = 1,
  parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int  BAUD_DIV    = 2604,
  localparam int RW          = (RESP_BYTES > 0) ? 8*RESP_BYTES : 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  output logic                   TX,
  input  logic                   send_cmd,
  input  logic [8*CMD_BYTES-1:0] cmd,
  output logic                   busy,
  output logic                   cmd_sent,
  output logic                   resp_rdy,
  output logic [RW-1:0]          resp,
  output logic                   resp_timeout
);

`ifdef REMOTE_COMM_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  localparam int NTX = CMD_BYTES + CHK;
  localparam int NRX = RESP_BYTES + CHK;
  localparam int TCW = (NTX > 1) ? $clog2(NTX) : 1;
  localparam int RCW = (NRX > 1) ? $clog2(NRX) : 1;
  localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TCW-1:0] TX_LAST = TCW'(NTX - 1);
  localparam logic [RCW-1:0] RX_LAST = RCW'((NRX > 0) ? NRX - 1 : 0);
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [8*NTX-1:0] tx_shft;
  logic [TCW-1:0]   tx_cnt;
  logic [RCW-1:0]   rx_cnt;
  logic [TW-1:0]    tcnt;
  logic             trmt;
  logic             tx_done;
  logic             rx_rdy;
  logic             clr_rx_rdy;
  logic [7:0]       rx_data;
`ifdef REMOTE_COMM_CHKSUM_EN
  logic [7:0]       rx_sum;
`endif

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (~rst),
    .RX         (RX),
    .TX         (TX),
    .trmt       (trmt),
    .tx_data    (tx_shft[8*NTX-1 -: 8]),
    .tx_done    (tx_done),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data)
  );

  // Every received byte is consumed immediately: used in RX_WAIT, dropped elsewhere.
  assign clr_rx_rdy = rx_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx_shft      <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      tcnt         <= '0;
      trmt         <= 1'b0;
      busy         <= 1'b0;
      cmd_sent     <= 1'b0;
      resp_rdy     <= 1'b0;
      resp_timeout <= 1'b0;
      resp         <= '0;
`ifdef REMOTE_COMM_CHKSUM_EN
      rx_sum       <= 8'h00;
`endif
    end else begin
      trmt <= 1'b0;
      case (state)
        IDLE: begin
          if (send_cmd) begin
`ifdef REMOTE_COMM_CHKSUM_EN
            tx_shft <= {cmd, chksum8(64'(cmd), CMD_BYTES)};
`else
            tx_shft <= cmd;
`endif
            tx_cnt       <= TX_LAST;
            cmd_sent     <= 1'b0;
            resp_rdy     <= 1'b0;
            resp_timeout <= 1'b0;
            busy         <= 1'b1;
            trmt         <= 1'b1;
            state        <= TX_LOAD;
          end
        end

        // trmt is registered on entry, so it is high during exactly this cycle.
        TX_LOAD: state <= TX_WAIT;

        TX_WAIT: begin
          if (tx_done) begin
            tx_shft <= tx_shft << 8;
            if (tx_cnt != '0) begin
              tx_cnt <= tx_cnt - 1'b1;
              trmt   <= 1'b1;
              state  <= TX_LOAD;
            end else begin
              cmd_sent <= 1'b1;
              tcnt     <= '0;
              rx_cnt   <= '0;
`ifdef REMOTE_COMM_CHKSUM_EN
              rx_sum   <= 8'h00;
`endif
              if (NRX == 0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= RX_WAIT;
              end
            end
          end
        end

        // A final byte arriving on the timeout cycle still counts as success.
        RX_WAIT: begin
          if (rx_rdy) begin
            if (int'(rx_cnt) < RESP_BYTES) resp <= RW'({resp, rx_data});
`ifdef REMOTE_COMM_CHKSUM_EN
            rx_sum <= rx_sum + rx_data;
`endif
            if (rx_cnt != RX_LAST) rx_cnt <= rx_cnt + 1'b1;
          end
          if (rx_rdy && rx_cnt == RX_LAST) begin
`ifdef REMOTE_COMM_CHKSUM_EN
            if (rx_sum + rx_data == 8'h00) resp_rdy <= 1'b1;
            else resp_timeout <= 1'b1;
`else
            resp_rdy <= 1'b1;
`endif
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tcnt == T_LAST) begin
            resp_timeout <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm_nbyte.sv
// Directed self-checking bench for remote_comm_nbyte with a serial model on TX/RX.
// Build with REMOTE_COMM_CHKSUM_EN to also exercise the checksum byte.
module tb_remote_comm_nbyte;

  localparam int CMD_BYTES   = 2;
  localparam int RESP_BYTES  = 2;
  localparam int TIMEOUT_CYC = 1000;
  localparam int BAUD_DIV    = 8;
`ifdef REMOTE_COMM_CHKSUM_EN
  localparam int NTX = CMD_BYTES + 1;
`else
  localparam int NTX = CMD_BYTES;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RX = 1'b1;
  logic        send_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        TX;
  logic        busy, cmd_sent, resp_rdy, resp_timeout;
  logic [15:0] resp;

  int checks = 0;
  int errors = 0;
  int trmt_cnt = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  remote_comm_nbyte #(
    .CMD_BYTES  (CMD_BYTES),
    .RESP_BYTES (RESP_BYTES),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .BAUD_DIV   (BAUD_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RX           (RX),
    .TX           (TX),
    .send_cmd     (send_cmd),
    .cmd          (cmd),
    .busy         (busy),
    .cmd_sent     (cmd_sent),
    .resp_rdy     (resp_rdy),
    .resp         (resp),
    .resp_timeout (resp_timeout)
  );

  always @(posedge clk) if (dut.trmt === 1'b1) trmt_cnt <= trmt_cnt + 1;

  // Serial receiver model capturing every byte the DUT puts on TX.
  initial begin
    forever begin : mon
      logic [7:0] b;
      @(negedge TX);
      repeat (BAUD_DIV/2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BAUD_DIV) @(posedge clk);
        b[i] = TX;
      end
      txq.push_back(b);
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef REMOTE_COMM_CHKSUM_EN
  function automatic logic [7:0] chk8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    return 8'h00 - s;
  endfunction
`endif

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  task automatic send_resp(input logic [7:0] a, input logic [7:0] b);
    send_byte(a);
    send_byte(b);
`ifdef REMOTE_COMM_CHKSUM_EN
    send_byte(chk8(a, b));
`endif
  endtask

  task automatic start_cmd(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
  endtask

  task automatic wait_sent(output bit ok, output int drops);
    drops = 0;
    for (int i = 0; i < 4000; i++) begin
      if (cmd_sent) break;
      if (!busy) drops++;
      @(negedge clk);
    end
    ok = cmd_sent;
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 3000; i++) begin
      if (resp_rdy || resp_timeout) break;
      @(negedge clk);
    end
    ok = resp_rdy || resp_timeout;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", TX); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cmd_sent !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_sent: got %b expected 0", cmd_sent); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_rdy: got %b expected 0", resp_rdy); end
    checks++; if (resp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_timeout: got %b expected 0", resp_timeout); end
    checks++; if (resp !== 16'h0000) begin errors++; $display("[TB] FAIL reset_resp: got %h expected 0000", resp); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd_tx;
    logic [7:0] exp_b [3];
    bit ok;
    int drops, t0;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'h01;
    txq.delete();
    t0 = trmt_cnt;
    start_cmd(16'hA55A);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL cmd_busy_start: got %b expected 1", busy); end
    wait_sent(ok, drops);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL cmd_sent_wait: cmd_sent got 0 expected 1"); end
    checks++; if (drops != 0) begin errors++; $display("[TB] FAIL cmd_busy_held: busy low for %0d cycles expected 0", drops); end
    checks++; if (trmt_cnt - t0 != NTX) begin errors++; $display("[TB] FAIL cmd_trmt_pulses: got %0d expected %0d", trmt_cnt - t0, NTX); end
    checks++; if (dut.tx_done !== 1'b1) begin errors++; $display("[TB] FAIL cmd_tx_done: got %b expected 1", dut.tx_done); end
    for (int i = 0; i < NTX; i++) begin
      checks++;
      if (txq.size() <= i) begin errors++; $display("[TB] FAIL cmd_tx_byte%0d: got none expected %h", i, exp_b[i]); end
      else if (txq[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL cmd_tx_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
    end
    send_resp(8'hBE, 8'hEF);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL resp_wait: no completion expected resp_rdy"); end
    checks++; if (resp !== 16'hBEEF) begin errors++; $display("[TB] FAIL resp_value: got %h expected beef", resp); end
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL resp_rdy: got %b expected 1", resp_rdy); end
    checks++; if (resp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL resp_no_timeout: got %b expected 0", resp_timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL resp_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_timeout;
    bit ok;
    int drops, n;
    start_cmd(16'h0F0F);
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL to_rdy_cleared: got %b expected 0", resp_rdy); end
    wait_sent(ok, drops);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL to_sent_wait: cmd_sent got 0 expected 1"); end
    n = 0;
    while (!resp_timeout && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != TIMEOUT_CYC) begin errors++; $display("[TB] FAIL to_latency: got %0d cycles expected %0d", n, TIMEOUT_CYC); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL to_resp_rdy: got %b expected 0", resp_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL to_busy: got %b expected 0", busy); end
    checks++; if (resp !== 16'hBEEF) begin errors++; $display("[TB] FAIL to_resp_held: got %h expected beef", resp); end
    start_cmd(16'h1234);
    checks++; if (resp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_cleared_by_cmd: got %b expected 0", resp_timeout); end
    wait_sent(ok, drops);
    send_byte(8'h77);
    wait_done(ok);
    checks++; if (resp_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_partial_flag: got %b expected 1", resp_timeout); end
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("[TB] FAIL to_partial_rdy: got %b expected 0", resp_rdy); end
    checks++; if (resp !== 16'hEF77) begin errors++; $display("[TB] FAIL to_partial_resp: got %h expected ef77", resp); end
  endtask

  task automatic test_ignore_busy;
    logic [7:0] exp_b [3];
    bit ok;
    int drops;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'hCD;
    txq.delete();
    start_cmd(16'h1122);
    repeat (40) @(negedge clk);
    start_cmd(16'h3344);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy: got %b expected 1", busy); end
    wait_sent(ok, drops);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ign_sent_wait: cmd_sent got 0 expected 1"); end
    checks++; if (txq.size() != NTX) begin errors++; $display("[TB] FAIL ign_byte_count: got %0d expected %0d", txq.size(), NTX); end
    for (int i = 0; i < NTX; i++) begin
      checks++;
      if (txq.size() <= i) begin errors++; $display("[TB] FAIL ign_tx_byte%0d: got none expected %h", i, exp_b[i]); end
      else if (txq[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL ign_tx_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
    end
    send_resp(8'h5A, 8'hA5);
    wait_done(ok);
    checks++; if (resp !== 16'h5AA5 || resp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL ign_resp: got %h rdy %b expected 5aa5 rdy 1", resp, resp_rdy); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_b [3];
    bit ok;
    int drops, t0, k;
    exp_b[0] = 8'h69; exp_b[1] = 8'h96; exp_b[2] = 8'h01;
    t0 = trmt_cnt;
    start_cmd(16'hC3C3);
    k = 0;
    while (trmt_cnt - t0 < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checks++; if (trmt_cnt - t0 < 2) begin errors++; $display("[TB] FAIL rm_second_byte: got %0d trmt expected 2", trmt_cnt - t0); end
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("[TB] FAIL rm_tx_high: got %b expected 1", TX); end
    checks++; if ({busy, cmd_sent, resp_rdy, resp_timeout} !== 4'b0000) begin errors++; $display("[TB] FAIL rm_flags: got %b expected 0000", {busy, cmd_sent, resp_rdy, resp_timeout}); end
    checks++; if (resp !== 16'h0000) begin errors++; $display("[TB] FAIL rm_resp: got %h expected 0000", resp); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20*BAUD_DIV) @(negedge clk);
    checks++; if ({busy, cmd_sent, resp_rdy, resp_timeout} !== 4'b0000) begin errors++; $display("[TB] FAIL rm_after_release: got %b expected 0000", {busy, cmd_sent, resp_rdy, resp_timeout}); end
    txq.delete();
    start_cmd(16'h6996);
    wait_sent(ok, drops);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rm_sent_wait: cmd_sent got 0 expected 1"); end
    for (int i = 0; i < NTX; i++) begin
      checks++;
      if (txq.size() <= i) begin errors++; $display("[TB] FAIL rm_tx_byte%0d: got none expected %h", i, exp_b[i]); end
      else if (txq[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL rm_tx_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
    end
    send_resp(8'h12, 8'h34);
    wait_done(ok);
    checks++; if (resp !== 16'h1234 || resp_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rm_resp_after: got %h rdy %b expected 1234 rdy 1", resp, resp_rdy); end
  endtask

`ifdef REMOTE_COMM_CHKSUM_EN
  task automatic test_chksum;
    logic [7:0] exp_b [3];
    bit ok;
    int drops;
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'hFD;
    txq.delete();
    start_cmd(16'h0102);
    wait_sent(ok, drops);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (txq.size() <= i) begin errors++; $display("[TB] FAIL ck_tx_byte%0d: got none expected %h", i, exp_b[i]); end
      else if (txq[i] !== exp_b[i]) begin errors++; $display("[TB] FAIL ck_tx_byte%0d: got %h expected %h", i, txq[i], exp_b[i]); end
    end
    send_byte(8'h40); send_byte(8'hC0); send_byte(8'h00);
    wait_done(ok);
    checks++; if (resp_rdy !== 1'b1 || resp_timeout !== 1'b0 || resp !== 16'h40C0) begin errors++; $display("[TB] FAIL ck_good: got rdy %b to %b resp %h expected 1 0 40c0", resp_rdy, resp_timeout, resp); end
    start_cmd(16'h0102);
    wait_sent(ok, drops);
    send_byte(8'h40); send_byte(8'hC1); send_byte(8'h00);
    wait_done(ok);
    checks++; if (resp_rdy !== 1'b0 || resp_timeout !== 1'b1 || resp !== 16'h40C1) begin errors++; $display("[TB] FAIL ck_bad: got rdy %b to %b resp %h expected 0 1 40c1", resp_rdy, resp_timeout, resp); end
  endtask
`endif

  initial begin
    test_reset();
    test_cmd_tx();
    test_timeout();
    test_ignore_busy();
    test_reset_mid();
`ifdef REMOTE_COMM_CHKSUM_EN
    test_chksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
